ball_vertical_velocity: RTL and testbench
=========================================

// Module: ball_vertical_velocity
// PURPOSE
//  Vertical velocity control for the ball: registers paddle-hit angle and top/bottom wall bounces, and
//  presents the 4-bit load value {db,cb,bb,ab} consumed by the ball vertical counter at each carry.
//  Sits between hit detection / paddle vertical counter (upstream) and the ball vertical counter (downstream).
//  Fully synchronous on clk; video-timing inputs are sampled as levels and edge-detected internally.
// PARAMETERS
//  VEL_NEUTRAL  8  load nibble meaning zero vertical motion; output = VEL_NEUTRAL + vel (signed)
// PORTS
//  clk      in   1  master clock; all state on rising edge
//  _reset   in   1  asynchronous, active-low reset
//  _hsync   in   1  horizontal sync (active-low); falling edge = line tick
//  _vblank  in   1  vertical blank (active-low)
//  vvid     in   1  ball vertical video window (from ball vertical counter)
//  vtop     in   1  1 while raster is in upper half of frame (selects top vs bottom wall)
//  hit      in   1  ball/paddle coincidence, level
//  pseg     in   3  paddle segment at hit, 0 = top segment .. 7 = bottom
//  serve    in   1  single-cycle pulse: new serve
//  ab,bb,cb,db out 1 each  velocity load nibble, ab = LSB
//  vel      out  4  signed current output velocity (debug/sound)
// BEHAVIOUR
//  - Reset: pend_vel=0, vel=0, {db,cb,bb,ab}=VEL_NEUTRAL (4'b1000), edge registers cleared.
//  - Segment table (magnitude): seg 0/7->3, 1/6->2, 2/5->1, 3/4->0; sign: seg 0-3 negative (up), 4-7 positive.
//  - Hit: rising edge of hit (registered edge detect) loads pend_vel from table; one load per hit edge,
//    held level has no further effect.
//  - Wall: wall = vvid & ~_vblank. If wall & vtop & pend_vel<0 -> pend_vel = -pend_vel.
//    If wall & ~vtop & pend_vel>0 -> pend_vel = -pend_vel. Direction gating makes bounce self-limiting
//    (ball lingering in blank for many lines reverses exactly once). pend_vel==0 never reverses.
//  - Serve pulse: pend_vel=0.
//  - Priority same cycle: serve > hit edge > wall.
//  - Output pipeline: pend_vel copied to vel/nibble only on the cycle after a _hsync falling edge is
//    detected, so the counter never sees a mid-line change. Latency event->pend_vel 1 clk (hit: 2 clk
//    incl. edge register); pend_vel->outputs next line tick + 1 clk.
//  - Arithmetic: pend_vel is 4-bit two's complement, range +-3 (+-4 with option); nibble = VEL_NEUTRAL + vel,
//    mod 16, never wraps within legal range (4..12).
//  - Reset asserted mid-frame: immediate return to reset values; first line tick after release outputs 8.
// CONFIGURATION
//  BALL_VEL_STEEP_EN defined: seg 0/7 magnitude 4 (nibble 4 or 12); others unchanged.
//  Undefined: table as above, max magnitude 3, nibble range 5..11.
// STRUCTURE
//  Shared package pong_pkg: vel_t (signed 4-bit), VEL_NEUTRAL constant, seg_to_vel() table function
//  (honours BALL_VEL_STEEP_EN). Sub-module edge_detect (rise/fall pulse, 1-clk delay) instanced for
//  _hsync and hit. Remaining logic inline: pend_vel register, output register.
// TESTING
//  1 reset release, 3 line ticks, no events -> vel=0, {db,cb,bb,ab}=4'b1000 throughout.
//  2 hit rise with pseg=0, then _hsync fall -> pend_vel=-3 after 2 clk; nibble=5 only after line tick+1 clk.
//  3 vel=+2, hold wall (vvid=1,_vblank=0,vtop=0) for 20 lines -> single reversal, nibble 10->6, stays 6.
//  4 vel=-1, wall with vtop=0 (wrong wall) -> no change, nibble stays 7.
//  5 hit edge (pseg=6) and wall same cycle with vel=-2,vtop=1 -> hit wins, pend_vel=+2; serve with hit -> 0.
//  6 BALL_VEL_STEEP_EN build: pseg=7 hit -> nibble=12; non-EN build -> 11. Reset mid-line -> 8 immediately.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared ball velocity types, constants and segment table (BALL_VEL_STEEP_EN)
package pong_pkg;

  typedef logic signed [3:0] vel_t;

  localparam int VEL_NEUTRAL = 8;

  // Snapshot presented to the ball vertical counter each line.
  typedef struct packed {
    vel_t       vel;
    logic [3:0] nib;
  } vel_out_t;

  // Outer paddle segments give the steepest angle; upper half of the paddle sends the ball up.
  function automatic vel_t seg_to_vel(input logic [2:0] seg);
    vel_t mag;
    case (seg)
      3'd0, 3'd7: begin
`ifdef BALL_VEL_STEEP_EN
        mag = 4'sd4;
`else
        mag = 4'sd3;
`endif
      end
      3'd1, 3'd6: mag = 4'sd2;
      3'd2, 3'd5: mag = 4'sd1;
      default:    mag = 4'sd0;
    endcase
    return seg[2] ? mag : -mag;
  endfunction

endpackage

// File: rtl/ball_vertical_velocity_if.sv
// rtl/ball_vertical_velocity_if.sv - video timing, hit and velocity nibble signals of the ball velocity block
interface ball_vertical_velocity_if;
  import pong_pkg::*;

  logic       _hsync;
  logic       _vblank;
  logic       vvid;
  logic       vtop;
  logic       hit;
  logic [2:0] pseg;
  logic       serve;
  logic       ab;
  logic       bb;
  logic       cb;
  logic       db;
  vel_t       vel;

  modport master (
    output _hsync, _vblank, vvid, vtop, hit, pseg, serve,
    input  ab, bb, cb, db, vel
  );

  modport slave (
    input  _hsync, _vblank, vvid, vtop, hit, pseg, serve,
    output ab, bb, cb, db, vel
  );

endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered level sampler producing a one-clock rise or fall pulse
module edge_detect #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= {hist_q[0], sig_i};
    end
  end

  // hist_q[0] is the newest sample, hist_q[1] the one before it.
  assign pulse_o = RISE ? (hist_q[0] & ~hist_q[1]) : (~hist_q[0] & hist_q[1]);

endmodule

// File: rtl/ball_vertical_velocity.sv
// rtl/ball_vertical_velocity.sv - ball vertical velocity: paddle angle, wall bounce, per-line load nibble (BALL_VEL_STEEP_EN)
module ball_vertical_velocity
  import pong_pkg::*;
#(
  parameter int VEL_NEUTRAL = pong_pkg::VEL_NEUTRAL
) (
  input  logic                      clk,
  input  logic                      _reset,
  ball_vertical_velocity_if.slave   bus
);

  logic     hit_rise;
  logic     line_tick;
  logic     wall;
  logic     pend_neg;
  logic     pend_pos;
  vel_t     pend_vel_q, pend_vel_d;
  vel_out_t out_q, out_d;

  edge_detect #(.RISE(1'b1)) u_hit_edge (
    .clk     (clk),
    .rst_n   (_reset),
    .sig_i   (bus.hit),
    .pulse_o (hit_rise)
  );

  edge_detect #(.RISE(1'b0)) u_hsync_edge (
    .clk     (clk),
    .rst_n   (_reset),
    .sig_i   (bus._hsync),
    .pulse_o (line_tick)
  );

  assign wall     = bus.vvid & ~bus._vblank;
  assign pend_neg = pend_vel_q[3];
  assign pend_pos = ~pend_vel_q[3] & (pend_vel_q != 4'sd0);

  // Reversal only when moving toward the wall being touched, so a long stay in blank flips once.
  always_comb begin
    pend_vel_d = pend_vel_q;
    if (bus.serve) begin
      pend_vel_d = 4'sd0;
    end else if (hit_rise) begin
      pend_vel_d = seg_to_vel(bus.pseg);
    end else if (wall && bus.vtop && pend_neg) begin
      pend_vel_d = -pend_vel_q;
    end else if (wall && !bus.vtop && pend_pos) begin
      pend_vel_d = -pend_vel_q;
    end
  end

  // Outputs move only at a line boundary so the vertical counter never reloads mid-line.
  always_comb begin
    out_d = out_q;
    if (line_tick) begin
      out_d.vel = pend_vel_q;
      out_d.nib = 4'(VEL_NEUTRAL) + $unsigned(pend_vel_q);
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      pend_vel_q <= 4'sd0;
      out_q.vel  <= 4'sd0;
      out_q.nib  <= 4'(VEL_NEUTRAL);
    end else begin
      pend_vel_q <= pend_vel_d;
      out_q      <= out_d;
    end
  end

  assign {bus.db, bus.cb, bus.bb, bus.ab} = out_q.nib;
  assign bus.vel                          = out_q.vel;

endmodule

// File: tb/tb_ball_vertical_velocity.sv
// tb/tb_ball_vertical_velocity.sv - self-checking bench for ball_vertical_velocity against a line-level model
module tb_ball_vertical_velocity;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ball_vertical_velocity_if bus ();

  ball_vertical_velocity dut (
    .clk    (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the design should hold after the next rising edge.
  int m_pend;
  int m_vel;
  bit m_h1, m_h2, m_hs1, m_hs2;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int seg_vel(input int s);
    int mag_tbl[8];
    mag_tbl = '{3, 2, 1, 0, 0, 1, 2, 3};
`ifdef BALL_VEL_STEEP_EN
    mag_tbl[0] = 4;
    mag_tbl[7] = 4;
`endif
    return (s < 4) ? -mag_tbl[s] : mag_tbl[s];
  endfunction

  function automatic logic [3:0] nib_now();
    return {bus.db, bus.cb, bus.bb, bus.ab};
  endfunction

  task automatic model_reset();
    m_pend = 0;
    m_vel  = 0;
    m_h1   = 0;
    m_h2   = 0;
    m_hs1  = 0;
    m_hs2  = 0;
  endtask

  task automatic model_step(input bit hs, vb, vv, vt, h, input int ps, input bit sv);
    bit rise;
    bit fall;
    bit wall;
    int np;
    rise = m_h1 && !m_h2;
    fall = !m_hs1 && m_hs2;
    wall = vv && !vb;
    np   = m_pend;
    if (sv)                           np = 0;
    else if (rise)                    np = seg_vel(ps);
    else if (wall && vt && m_pend < 0)  np = -m_pend;
    else if (wall && !vt && m_pend > 0) np = -m_pend;
    if (fall) m_vel = m_pend;
    m_pend = np;
    m_h2   = m_h1;
    m_h1   = h;
    m_hs2  = m_hs1;
    m_hs1  = hs;
  endtask

  task automatic drive(input bit hs, vb, vv, vt, h, input int ps, input bit sv);
    bus._hsync  = hs;
    bus._vblank = vb;
    bus.vvid    = vv;
    bus.vtop    = vt;
    bus.hit     = h;
    bus.pseg    = 3'(ps);
    bus.serve   = sv;
  endtask

  // One clock: compare outputs, apply new inputs, advance the model across the coming edge.
  task automatic tick(input bit hs, vb, vv, vt, h, input int ps, input bit sv);
    @(negedge clk);
    check_val("nib", nib_now(), 4'(8 + m_vel));
    check_val("vel", bus.vel, 4'(m_vel));
    drive(hs, vb, vv, vt, h, ps, sv);
    model_step(hs, vb, vv, vt, h, ps, sv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic line(input bit vv, vb, vt);
    for (int i = 0; i < 32; i++) tick(i >= 4, vb, vv, vt, 0, 0, 0);
  endtask

  task automatic hit_pulse(input int ps);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 1, ps, 0);
    idle(2);
  endtask

  task automatic release_reset();
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0);
    model_step(1, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("reset_nib", nib_now(), 4'd8);
      check_val("reset_vel", bus.vel, 4'd0);
    end
    release_reset();

    // No events: neutral throughout.
    for (int i = 0; i < 3; i++) line(0, 1, 0);
    check_val("quiet_nib", nib_now(), 4'd8);

    // Top segment hit: steep upward, visible only after a line tick.
    hit_pulse(0);
    check_val("hit0_pre_tick", nib_now(), 4'd8);
    line(0, 1, 0);
    check_val("hit0_nib", nib_now(), 4'd5);

    // Bottom wall held for many lines reverses exactly once.
    hit_pulse(6);
    line(0, 1, 0);
    check_val("hit6_nib", nib_now(), 4'd10);
    for (int i = 0; i < 20; i++) line(1, 0, 0);
    check_val("bounce_nib", nib_now(), 4'd6);
    line(0, 1, 0);
    check_val("bounce_hold", nib_now(), 4'd6);

    // Moving up while touching the bottom wall: no reversal.
    hit_pulse(2);
    line(0, 1, 0);
    check_val("hit2_nib", nib_now(), 4'd7);
    for (int i = 0; i < 3; i++) line(1, 0, 0);
    check_val("wrong_wall", nib_now(), 4'd7);

    // Hit edge and top wall on the same clock: the hit load wins.
    hit_pulse(1);
    line(0, 1, 0);
    check_val("hit1_nib", nib_now(), 4'd6);
    tick(1, 1, 0, 1, 1, 5, 0);
    tick(1, 0, 1, 1, 1, 5, 0);
    tick(1, 1, 0, 1, 0, 5, 0);
    idle(2);
    line(0, 1, 0);
    check_val("hit_vs_wall", nib_now(), 4'd9);

    // Serve together with a hit edge clears the velocity.
    tick(1, 1, 0, 0, 1, 7, 0);
    tick(1, 1, 0, 0, 1, 7, 1);
    tick(1, 1, 0, 0, 0, 7, 0);
    idle(2);
    line(0, 1, 0);
    check_val("serve_vs_hit", nib_now(), 4'd8);

    // Outermost bottom segment.
    hit_pulse(7);
    line(0, 1, 0);
`ifdef BALL_VEL_STEEP_EN
    check_val("hit7_nib", nib_now(), 4'd12);
`else
    check_val("hit7_nib", nib_now(), 4'd11);
`endif

    // Reset mid-line returns to neutral at once.
    for (int i = 0; i < 10; i++) tick(i >= 4, 1, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_nib", nib_now(), 4'd8);
    check_val("rst_mid_vel", bus.vel, 4'd0);
    model_reset();
    release_reset();
    line(0, 1, 0);
    check_val("post_rst_nib", nib_now(), 4'd8);

    // Randomized lines: hits, serves and wall contacts at random positions.
    for (int ln = 0; ln < 40; ln++) begin
      bit vt;
      bit wall_on;
      int hit_at;
      int ps;
      int sv_at;
      vt      = 1'($urandom_range(0, 1));
      wall_on = ($urandom_range(0, 2) == 0);
      hit_at  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 28)) : 99;
      ps      = int'($urandom_range(0, 7));
      sv_at   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : 99;
      for (int i = 0; i < 32; i++) begin
        tick(i >= 4, !wall_on, wall_on && (i >= 8) && (i < 24), vt,
             (i >= hit_at) && (i < hit_at + 3), ps, i == sv_at);
      end
    end

    @(negedge clk);
    check_val("final_nib", nib_now(), 4'(8 + m_vel));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
